// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default widths, fixed-point helpers and
// the saturating narrow function used by the butterfly output stage.
package fft_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_TW_W   = 16;

  // Twiddles are Q(TW_W-2): two integer bits so that -2.0 is representable.
  function automatic int frac_bits(input int tw_w);
    return tw_w - 2;
  endfunction

  typedef struct packed {
    logic signed [DEF_DATA_W-1:0] re;
    logic signed [DEF_DATA_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [63:0] val;
    logic               clip;
  } sat_res_t;

  // Clamp a signed value into a signed field of the given width.
  function automatic sat_res_t sat_to_w(input logic signed [63:0] value, input int width);
    sat_res_t           res;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    res.clip = 1'b1;
    if (value > hi) begin
      res.val = hi;
    end else if (value < lo) begin
      res.val = lo;
    end else begin
      res.val  = value;
      res.clip = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/cplx_mult_round.sv
// Complex y*W (or y*conj(W)) with round-half-up back to data scale.
// Two register stages: raw partial products, then combined and rounded.
module cplx_mult_round
  import fft_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TW_W   = DEF_TW_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_hold,
  input  logic                  i_en,
  input  logic [2*DATA_W-1:0]   i_y,
  input  logic [2*TW_W-1:0]     i_tw,
  input  logic                  i_inv,
  output logic signed [DATA_W+3:0] o_tr,
  output logic signed [DATA_W+3:0] o_tj,
  output logic                  o_valid
);

  localparam int P_W  = DATA_W + TW_W + 1;
  localparam int S_W  = P_W + 1;
  localparam int FRAC = frac_bits(TW_W);
  localparam int T_W  = DATA_W + 4;
  localparam logic signed [S_W-1:0] HALF = S_W'(1) <<< (FRAC - 1);

  logic signed [DATA_W-1:0] yr, yj;
  logic signed [TW_W-1:0]   twr, twj;
  logic signed [TW_W:0]     twj_e;
  logic signed [P_W-1:0]    m_rr, m_jj, m_rj, m_jr;
  logic signed [P_W-1:0]    p_rr, p_jj, p_rj, p_jr;
  logic                     v1;
  logic signed [S_W-1:0]    pr, pj;
  logic signed [T_W-1:0]    tr_c, tj_c;

  assign yr  = i_y[2*DATA_W-1:DATA_W];
  assign yj  = i_y[DATA_W-1:0];
  assign twr = i_tw[2*TW_W-1:TW_W];
  assign twj = i_tw[TW_W-1:0];

  // Conjugation done one bit wider so negating the most negative twiddle cannot wrap.
  assign twj_e = i_inv ? -((TW_W+1)'(twj)) : (TW_W+1)'(twj);

  // Four real partial products at full precision.
  always_comb begin
    m_rr = P_W'(yr) * P_W'(twr);
    m_jj = P_W'(yj) * P_W'(twj_e);
    m_rj = P_W'(yr) * P_W'(twj_e);
    m_jr = P_W'(yj) * P_W'(twr);
  end

  // Stage 1: register partial products; invalid cycles load zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1   <= 1'b0;
      p_rr <= '0;
      p_jj <= '0;
      p_rj <= '0;
      p_jr <= '0;
    end else if (!i_hold) begin
      v1 <= i_en;
      if (i_en) begin
        p_rr <= m_rr;
        p_jj <= m_jj;
        p_rj <= m_rj;
        p_jr <= m_jr;
      end else begin
        p_rr <= '0;
        p_jj <= '0;
        p_rj <= '0;
        p_jr <= '0;
      end
    end
  end

  // Combine into real/imag products and round half-up to data scale; the
  // shifted result is exactly T_W bits wide so nothing significant is lost.
  always_comb begin
    pr   = S_W'(p_rr) - S_W'(p_jj);
    pj   = S_W'(p_rj) + S_W'(p_jr);
    tr_c = T_W'((pr + HALF) >>> FRAC);
    tj_c = T_W'((pj + HALF) >>> FRAC);
  end

  // Stage 2: register the rounded product.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_tr    <= '0;
      o_tj    <= '0;
    end else if (!i_hold) begin
      o_valid <= v1;
      if (v1) begin
        o_tr <= tr_c;
        o_tj <= tj_c;
      end else begin
        o_tr <= '0;
        o_tj <= '0;
      end
    end
  end

endmodule

// File: rtl/butterfly_unit_param.sv
// Radix-2 DIT butterfly: o_x = x + y*W, o_y = x - y*W, three-stage pipeline
// with optional halving, saturation and a sticky overflow flag.
module butterfly_unit_param
  import fft_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TW_W   = DEF_TW_W,
  parameter int TAG_W  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_hold,
  input  logic [2*DATA_W-1:0] i_x,
  input  logic [2*DATA_W-1:0] i_y,
  input  logic [2*TW_W-1:0]   i_tw,
  input  logic                i_inv,
  input  logic                i_scale,
  input  logic [TAG_W-1:0]    i_tag,
  input  logic                i_clr_ovf,
  output logic [2*DATA_W-1:0] o_x,
  output logic [2*DATA_W-1:0] o_y,
  output logic [TAG_W-1:0]    o_tag,
  output logic                o_en,
  output logic                o_ovf
);

  localparam int A_W = DATA_W + 4;

  logic signed [A_W-1:0]    tr, tj;
  logic                     v2;
  logic [2*DATA_W-1:0]      x1, x2;
  logic [TAG_W-1:0]         tag1, tag2;
  logic                     scale1, scale2;
  logic signed [DATA_W-1:0] xr2, xj2;
  logic signed [A_W-1:0]    axr, axj, ayr, ayj;
  sat_res_t                 s_xr, s_xj, s_yr, s_yj;
  logic                     clip_any;

  cplx_mult_round #(
    .DATA_W (DATA_W),
    .TW_W   (TW_W)
  ) u_mult (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_hold  (i_hold),
    .i_en    (i_en),
    .i_y     (i_y),
    .i_tw    (i_tw),
    .i_inv   (i_inv),
    .o_tr    (tr),
    .o_tj    (tj),
    .o_valid (v2)
  );

  // Sideband delay line matching the multiplier; zeros follow invalid slots.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x1     <= '0;
      tag1   <= '0;
      scale1 <= 1'b0;
      x2     <= '0;
      tag2   <= '0;
      scale2 <= 1'b0;
    end else if (!i_hold) begin
      if (i_en) begin
        x1     <= i_x;
        tag1   <= i_tag;
        scale1 <= i_scale;
      end else begin
        x1     <= '0;
        tag1   <= '0;
        scale1 <= 1'b0;
      end
      x2     <= x1;
      tag2   <= tag1;
      scale2 <= scale1;
    end
  end

  assign xr2 = x2[2*DATA_W-1:DATA_W];
  assign xj2 = x2[DATA_W-1:0];

  // Add/subtract with headroom, optional round-half-up halving, then clamp.
  always_comb begin
    axr = A_W'(xr2) + tr;
    axj = A_W'(xj2) + tj;
    ayr = A_W'(xr2) - tr;
    ayj = A_W'(xj2) - tj;
    if (scale2) begin
      axr = (axr + A_W'(1)) >>> 1;
      axj = (axj + A_W'(1)) >>> 1;
      ayr = (ayr + A_W'(1)) >>> 1;
      ayj = (ayj + A_W'(1)) >>> 1;
    end
    s_xr     = sat_to_w(64'(axr), DATA_W);
    s_xj     = sat_to_w(64'(axj), DATA_W);
    s_yr     = sat_to_w(64'(ayr), DATA_W);
    s_yj     = sat_to_w(64'(ayj), DATA_W);
    clip_any = s_xr.clip | s_xj.clip | s_yr.clip | s_yj.clip;
  end

  // Stage 3: output registers and sticky overflow (set beats clear).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_x   <= '0;
      o_y   <= '0;
      o_tag <= '0;
      o_en  <= 1'b0;
      o_ovf <= 1'b0;
    end else if (!i_hold) begin
      o_en <= v2;
      if (v2) begin
        o_x   <= {DATA_W'(s_xr.val), DATA_W'(s_xj.val)};
        o_y   <= {DATA_W'(s_yr.val), DATA_W'(s_yj.val)};
        o_tag <= tag2;
      end else begin
        o_x   <= '0;
        o_y   <= '0;
        o_tag <= '0;
      end
      if (v2 && clip_any) begin
        o_ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        o_ovf <= 1'b0;
      end
    end
  end

endmodule
